// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one downstream cache port between two requesters.
// Owns the downstream enable/write handshake and routes completion back to the granted port only.
module cache_port_arbiter #(
    parameter int unsigned ADDR_LENGTH = 10,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_LENGTH-1:0] addrIn0,
    input  logic [ADDR_LENGTH-1:0] addrIn1,
    input  logic [DATA_WIDTH-1:0]  dataUpIn0,
    input  logic [DATA_WIDTH-1:0]  dataUpIn1,
    input  logic                   enableIn0,
    input  logic                   enableIn1,
    input  logic                   writeIn0,
    input  logic                   writeIn1,
    output logic [DATA_WIDTH-1:0]  dataUpOut0,
    output logic [DATA_WIDTH-1:0]  dataUpOut1,
    output logic                   fetchComplete0,
    output logic                   fetchComplete1,
    output logic                   writeCompleteOut0,
    output logic                   writeCompleteOut1,
    output logic [ADDR_LENGTH-1:0] addrOut,
    output logic [DATA_WIDTH-1:0]  dataDownOut,
    input  logic [DATA_WIDTH-1:0]  dataDownIn,
    output logic                   enableOut,
    output logic                   writeOut,
    input  logic                   fetchReceive,
    input  logic                   writeCompleteIn,
    output logic                   grant,
    output logic                   timeoutErr
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    enable_q, enable_d;
    logic [1:0]              fetch_q, fetch_d;
    logic [1:0]              wcomp_q, wcomp_d;
    logic                    terr_q, terr_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

    logic [1:0]              req_c;
    logic [1:0]              wr_c;
    logic                    down_done_c;
    logic                    finish_c;
    logic [DATA_WIDTH-1:0]   ret_c;

    assign req_c       = {enableIn1, enableIn0};
    assign wr_c        = {writeIn1, writeIn0};
    // Only the completion type matching the granted request counts.
    assign down_done_c = wr_c[grant_q] ? writeCompleteIn : fetchReceive;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b1;
            timer_q  <= '0;
            enable_q <= 1'b0;
            fetch_q  <= '0;
            wcomp_q  <= '0;
            terr_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            enable_q <= enable_d;
            fetch_q  <= fetch_d;
            wcomp_q  <= wcomp_d;
            terr_q   <= terr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        timer_d  = timer_q;
        enable_d = enable_q;
        fetch_d  = fetch_q;
        wcomp_d  = wcomp_q;
        terr_d   = terr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        finish_c = 1'b0;
        ret_c    = '0;

        unique case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                fetch_d  = '0;
                wcomp_d  = '0;
                if (req_c != 2'b00) begin
                    // Prefer the port that did not win last time.
                    grant_d  = req_c[~grant_q] ? ~grant_q : grant_q;
                    timer_d  = '0;
                    enable_d = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                timer_d = timer_q + TW'(1);
                if (!req_c[grant_q]) begin
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end else if (down_done_c) begin
                    finish_c = 1'b1;
                    ret_c    = dataDownIn;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    finish_c = 1'b1;
                    terr_d   = 1'b1;
                end
                if (finish_c) begin
                    enable_d = 1'b0;
                    state_d  = DONE;
                    if (wr_c[grant_q]) begin
                        wcomp_d[grant_q] = 1'b1;
                    end else begin
                        fetch_d[grant_q] = 1'b1;
                        if (grant_q) rdata1_d = ret_c;
                        else         rdata0_d = ret_c;
                    end
                end
            end
            DONE: begin
                enable_d = 1'b0;
                if (!req_c[grant_q]) begin
                    fetch_d = '0;
                    wcomp_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream request fields follow the granted port only while a transaction is in flight.
    assign addrOut     = (state_q == BUSY) ? (grant_q ? addrIn1 : addrIn0) : '0;
    assign dataDownOut = (state_q == BUSY) ? (grant_q ? dataUpIn1 : dataUpIn0) : '0;
    assign writeOut    = (state_q == BUSY) & wr_c[grant_q];

    assign enableOut         = enable_q;
    assign grant             = grant_q;
    assign timeoutErr        = terr_q;
    assign fetchComplete0    = fetch_q[0];
    assign fetchComplete1    = fetch_q[1];
    assign writeCompleteOut0 = wcomp_q[0];
    assign writeCompleteOut1 = wcomp_q[1];
    assign dataUpOut0        = rdata0_q;
    assign dataUpOut1        = rdata1_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with hand-computed literal expectations.
module tb_cache_port_arbiter;

    localparam int TMO = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  addrIn0 = '0, addrIn1 = '0;
    logic [63:0] dataUpIn0 = '0, dataUpIn1 = '0;
    logic        enableIn0 = 1'b0, enableIn1 = 1'b0;
    logic        writeIn0 = 1'b0, writeIn1 = 1'b0;
    logic [63:0] dataUpOut0, dataUpOut1;
    logic        fetchComplete0, fetchComplete1;
    logic        writeCompleteOut0, writeCompleteOut1;
    logic [9:0]  addrOut;
    logic [63:0] dataDownOut;
    logic [63:0] dataDownIn = '0;
    logic        enableOut, writeOut;
    logic        fetchReceive = 1'b0;
    logic        writeCompleteIn = 1'b0;
    logic        grant, timeoutErr;

    cache_port_arbiter #(.ADDR_LENGTH(10), .DATA_WIDTH(64), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .addrIn0(addrIn0), .addrIn1(addrIn1),
        .dataUpIn0(dataUpIn0), .dataUpIn1(dataUpIn1),
        .enableIn0(enableIn0), .enableIn1(enableIn1),
        .writeIn0(writeIn0), .writeIn1(writeIn1),
        .dataUpOut0(dataUpOut0), .dataUpOut1(dataUpOut1),
        .fetchComplete0(fetchComplete0), .fetchComplete1(fetchComplete1),
        .writeCompleteOut0(writeCompleteOut0), .writeCompleteOut1(writeCompleteOut1),
        .addrOut(addrOut), .dataDownOut(dataDownOut), .dataDownIn(dataDownIn),
        .enableOut(enableOut), .writeOut(writeOut),
        .fetchReceive(fetchReceive), .writeCompleteIn(writeCompleteIn),
        .grant(grant), .timeoutErr(timeoutErr)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level reference: who owns the port, whether its result is being held, how long it has run.
    logic [1:0]  rq, wq;
    assign rq = {enableIn1, enableIn0};
    assign wq = {writeIn1, writeIn0};

    int          m_owner = -1;
    bit          m_hold  = 0;
    bit          m_wr    = 0;
    int          m_last  = 1;
    int          m_age   = 0;
    bit          m_err   = 0;
    logic [63:0] m_data0 = '0, m_data1 = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_owner = -1; m_hold = 0; m_wr = 0; m_last = 1; m_age = 0; m_err = 0;
            m_data0 = '0; m_data1 = '0;
        end else if (m_owner < 0) begin
            if (rq != 2'b00) begin
                m_owner = rq[1 - m_last] ? 1 - m_last : m_last;
                m_last  = m_owner;
                m_age   = 0;
                m_hold  = 0;
                m_wr    = wq[m_owner];
            end
        end else if (!m_hold) begin
            m_age++;
            if (!rq[m_owner]) begin
                m_owner = -1;
            end else if (m_wr ? writeCompleteIn : fetchReceive) begin
                m_hold = 1;
                if (!m_wr) begin
                    if (m_owner == 0) m_data0 = dataDownIn; else m_data1 = dataDownIn;
                end
            end else if (m_age == TMO) begin
                m_hold = 1;
                m_err  = 1;
                if (!m_wr) begin
                    if (m_owner == 0) m_data0 = '0; else m_data1 = '0;
                end
            end
        end else if (!rq[m_owner]) begin
            m_owner = -1;
            m_hold  = 0;
        end
    end

    task automatic compare_all();
        bit busy;
        busy = (m_owner >= 0) && !m_hold;
        check("enableOut", 64'(enableOut), 64'(busy));
        check("addrOut", 64'(addrOut), busy ? 64'(m_owner == 1 ? addrIn1 : addrIn0) : 64'd0);
        check("dataDownOut", dataDownOut, busy ? (m_owner == 1 ? dataUpIn1 : dataUpIn0) : 64'd0);
        check("writeOut", 64'(writeOut), 64'(busy && m_wr));
        check("grant", 64'(grant), 64'(m_last));
        check("timeoutErr", 64'(timeoutErr), 64'(m_err));
        check("fetchComplete0", 64'(fetchComplete0), 64'(m_hold && m_owner == 0 && !m_wr));
        check("fetchComplete1", 64'(fetchComplete1), 64'(m_hold && m_owner == 1 && !m_wr));
        check("writeCompleteOut0", 64'(writeCompleteOut0), 64'(m_hold && m_owner == 0 && m_wr));
        check("writeCompleteOut1", 64'(writeCompleteOut1), 64'(m_hold && m_owner == 1 && m_wr));
        check("dataUpOut0", dataUpOut0, m_data0);
        check("dataUpOut1", dataUpOut1, m_data1);
    endtask

    // Downstream responder: answers after resp_lat cycles of enableOut high, when enabled.
    bit          resp_on   = 1;
    int          resp_lat  = 4;
    logic [63:0] resp_data = '0;
    int          rcnt      = 0;

    always @(negedge clock) begin
        if (enableOut) rcnt++;
        else rcnt = 0;
        if (resp_on && enableOut && rcnt == resp_lat) begin
            if (writeOut) writeCompleteIn = 1'b1;
            else begin
                fetchReceive = 1'b1;
                dataDownIn   = resp_data;
            end
        end else begin
            fetchReceive    = 1'b0;
            writeCompleteIn = 1'b0;
        end
    end

    // Cycles with enableOut high, counted at the edge that ends each cycle.
    int en_cnt = 0;
    always @(posedge clock) if (enableOut) en_cnt++;

    task automatic wait_done(input int p, input string nm);
        int n;
        n = 0;
        while (!((p == 0) ? (fetchComplete0 | writeCompleteOut0)
                          : (fetchComplete1 | writeCompleteOut1)) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_completion_seen"}, 64'(n < 200), 64'd1);
    endtask

    task automatic measure_gap(input string nm);
        int gap;
        gap = 0;
        while (!enableOut && gap < 50) begin
            gap++;
            @(negedge clock);
        end
        check({nm, "_enable_gap"}, 64'(gap), 64'd2);
    endtask

    initial begin
        int base;
        fork
            forever begin
                @(posedge clock);
                #1;
                compare_all();
            end
        join_none

        repeat (2) @(negedge clock);
        check("reset_grant", 64'(grant), 64'd1);
        check("reset_enableOut", 64'(enableOut), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Simultaneous reads after reset: port 0 first, then port 1, then port 0 again.
        resp_on = 1; resp_lat = 3; resp_data = 64'hA0A0_0000_0000_0001;
        addrIn0 = 10'h020; addrIn1 = 10'h030;
        enableIn0 = 1; enableIn1 = 1;
        wait_done(0, "tie1_p0");
        check("tie1_grant", 64'(grant), 64'd0);
        check("tie1_p1_idle", 64'(fetchComplete1), 64'd0);
        check("tie1_data0", dataUpOut0, 64'hA0A0_0000_0000_0001);
        resp_data = 64'hB0B0_0000_0000_0002;
        enableIn0 = 0;
        measure_gap("tie1");
        check("tie1_then_p1", 64'(grant), 64'd1);
        wait_done(1, "tie1_p1");
        check("tie1_data1", dataUpOut1, 64'hB0B0_0000_0000_0002);
        enableIn1 = 0;
        @(negedge clock);
        enableIn0 = 1; enableIn1 = 1;
        wait_done(0, "tie2_p0");
        check("tie2_grant", 64'(grant), 64'd0);
        enableIn0 = 0;
        wait_done(1, "tie2_p1");
        enableIn1 = 0;
        repeat (2) @(negedge clock);

        // Single 12-cycle read on port 0.
        resp_lat = 12; resp_data = 64'hDEAD_BEEF_0000_0001;
        base = en_cnt;
        addrIn0 = 10'h004; enableIn0 = 1;
        wait_done(0, "rd");
        check("rd_enable_cycles", 64'(en_cnt - base), 64'd12);
        check("rd_fetch0", 64'(fetchComplete0), 64'd1);
        check("rd_data0", dataUpOut0, 64'hDEAD_BEEF_0000_0001);
        check("rd_grant", 64'(grant), 64'd0);
        check("rd_p1_fetch", 64'(fetchComplete1), 64'd0);
        enableIn0 = 0;
        repeat (2) @(negedge clock);

        // Port 1 write.
        resp_lat = 5;
        addrIn1 = 10'h010; dataUpIn1 = 64'hFFFF_FFFF; writeIn1 = 1; enableIn1 = 1;
        @(negedge clock);
        check("wr_writeOut", 64'(writeOut), 64'd1);
        check("wr_dataDownOut", dataDownOut, 64'hFFFF_FFFF);
        check("wr_addrOut", 64'(addrOut), 64'h010);
        wait_done(1, "wr");
        repeat (3) @(negedge clock);
        check("wr_hold", 64'(writeCompleteOut1), 64'd1);
        check("wr_no_fetch", 64'(fetchComplete1), 64'd0);
        enableIn1 = 0;
        @(negedge clock);
        check("wr_release", 64'(writeCompleteOut1), 64'd0);
        writeIn1 = 0;
        @(negedge clock);

        // Port 0 aborts in BUSY while port 1 waits.
        resp_on = 0;
        addrIn0 = 10'h044; addrIn1 = 10'h088;
        enableIn0 = 1; enableIn1 = 1;
        repeat (5) @(negedge clock);
        check("ab_owner", 64'(grant), 64'd0);
        resp_on = 1; resp_lat = 4; resp_data = 64'h0123_4567_89AB_CDEF;
        enableIn0 = 0;
        @(negedge clock);
        check("ab_enable_low", 64'(enableOut), 64'd0);
        check("ab_no_completion", 64'(fetchComplete0), 64'd0);
        @(negedge clock);
        check("ab_p1_granted", 64'(grant), 64'd1);
        check("ab_p1_enable", 64'(enableOut), 64'd1);
        wait_done(1, "ab_p1");
        check("ab_p1_data", dataUpOut1, 64'h0123_4567_89AB_CDEF);
        enableIn1 = 0;
        repeat (2) @(negedge clock);

        // Downstream never answers: forced abort after TMO busy cycles.
        resp_on = 0;
        base = en_cnt;
        addrIn0 = 10'h100; enableIn0 = 1;
        wait_done(0, "to");
        check("to_enable_cycles", 64'(en_cnt - base), 64'(TMO));
        check("to_err", 64'(timeoutErr), 64'd1);
        check("to_fetch0", 64'(fetchComplete0), 64'd1);
        check("to_data0", dataUpOut0, 64'd0);
        enableIn0 = 0;
        @(negedge clock);
        resp_on = 1; resp_lat = 3; resp_data = 64'h1234_5678_9ABC_DEF0;
        enableIn1 = 1;
        wait_done(1, "to_resume");
        check("to_resume_data", dataUpOut1, 64'h1234_5678_9ABC_DEF0);
        check("to_err_sticky", 64'(timeoutErr), 64'd1);
        enableIn1 = 0;
        repeat (2) @(negedge clock);

        // Reset pulsed mid-BUSY.
        resp_on = 0;
        enableIn1 = 1;
        repeat (3) @(negedge clock);
        check("rst_pre_enable", 64'(enableOut), 64'd1);
        #2;
        reset = 0;
        #1;
        check("rst_enableOut", 64'(enableOut), 64'd0);
        check("rst_timeoutErr", 64'(timeoutErr), 64'd0);
        check("rst_dataUpOut1", dataUpOut1, 64'd0);
        check("rst_fetch1", 64'(fetchComplete1), 64'd0);
        enableIn1 = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        resp_on = 1; resp_lat = 2; resp_data = 64'h5555_AAAA_5555_AAAA;
        enableIn0 = 1; enableIn1 = 1;
        wait_done(0, "rst_tie");
        check("rst_tie_grant", 64'(grant), 64'd0);
        enableIn0 = 0;
        wait_done(1, "rst_tie_p1");
        enableIn1 = 0;
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester round-robin arbiter that shares one downstream cache level (typically the L2 upstream port) between two upstream clients (e.g. an instruction L1 and a data L1). It owns the downstream enable/write handshake for the whole transaction. It guarantees at least one enable-low cycle between transactions so the downstream delay counter restarts. It returns data and completion only to the granted requester.

## Interface
- ADDR_LENGTH, 10, address width, both sides.
- DATA_WIDTH, 64, data width on both sides; equals the requesters' block size and the downstream RETURN_SIZE.
- TIMEOUT, 255, maximum BUSY cycles before a forced abort; counter width $clog2(TIMEOUT+1).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears while low.
- addrIn0 / addrIn1  in  ADDR_LENGTH  requester address.
- dataUpIn0 / dataUpIn1  in  DATA_WIDTH  requester write data.
- enableIn0 / enableIn1  in  1  request; level, held until completion is seen.
- writeIn0 / writeIn1  in  1  1 = write, 0 = read; stable while enable is high.
- dataUpOut0 / dataUpOut1  out  DATA_WIDTH  latched read data.
- fetchComplete0 / fetchComplete1  out  1  read done; level.
- writeCompleteOut0 / writeCompleteOut1  out  1  write done; level.
- addrOut  out  ADDR_LENGTH  downstream address.
- dataDownOut  out  DATA_WIDTH  downstream write data.
- dataDownIn  in  DATA_WIDTH  downstream read data.
- enableOut  out  1  downstream enable; registered.
- writeOut  out  1  downstream write.
- fetchReceive  in  1  downstream read done.
- writeCompleteIn  in  1  downstream write done.
- grant  out  1  index of the current or last granted port.
- timeoutErr  out  1  sticky abort flag; cleared only by reset.

## Operation
- States: IDLE, BUSY, DONE. All outputs are 0 at reset; state is IDLE; grant=1, so port 0 wins the first tie.
- IDLE, no enable: hold.
- IDLE, enable present: grant the port that is not `grant` if it requests, else the requesting port. Update `grant`, clear the timer, go BUSY.
- BUSY outputs: enableOut=1. addrOut, dataDownOut and writeOut are driven from the granted port's inputs via a mux on `grant`. The timer increments every cycle.
- BUSY, downstream done: completion is fetchReceive when writeIn=0 and writeCompleteIn when writeIn=1. Latch dataDownIn into dataUpOut[grant] on reads. Go DONE.
- BUSY, granted enableIn drops before completion (abort): go IDLE with no completion.
- BUSY, timer reaches TIMEOUT: set timeoutErr and go DONE. The matching completion is asserted with read data = 0.
- DONE outputs: enableOut=0, addrOut=0, writeOut=0. fetchComplete[grant] or writeCompleteOut[grant] is held high and dataUpOut held stable.
- DONE, granted enableIn low: go IDLE, and the completion output drops the same edge.
- Non-granted completion outputs are always 0. dataUpOut of each port holds its last value until overwritten.

## Timing
- Request seen high at edge N in IDLE: enableOut=1 from edge N onward (registered).
- Downstream completion seen at edge M: from edge M, completion is high and enableOut=0.
- Minimum enableOut-low gap between transactions: 2 cycles (DONE, then IDLE).
- Completion latency = downstream latency + 1 cycle at each end.
- Both requests rise in the same cycle: the port other than `grant` wins. The loser stays pending and is granted on the first IDLE edge after the winner releases.
- A request arriving during BUSY/DONE of the other port waits; there is no preemption.
- fetchReceive and writeCompleteIn while IDLE/DONE are ignored. The wrong completion type in BUSY (e.g. writeCompleteIn on a read) is ignored.
- Reset low mid-BUSY: all outputs go to 0 immediately (asynchronous), and the transaction is lost.

## Test plan
- Single read, port 0, addr 0x004; downstream returns 64'hDEAD_BEEF_0000_0001 after 12 cycles -> enableOut high 12 cycles, fetchComplete0=1 with that data, port 1 outputs 0, grant=0.
- Simultaneous reads from both ports after reset -> port 0 served first, then enableOut low ≥2 cycles, then port 1 served. Next simultaneous pair -> port 0 served first again, since the other-than-last rule alternates.
- Port 1 write, addr 0x010, data 64'hFFFF_FFFF -> writeOut=1 and dataDownOut matches during BUSY; writeCompleteOut1 held until enableIn1 falls; fetchComplete1 stays 0.
- Port 0 drops enable at cycle 5 of BUSY -> enableOut low next edge, no completion; pending port 1 granted afterwards.
- Downstream never completes, TIMEOUT=20 -> after 20 BUSY cycles timeoutErr=1, completion asserted with data 0, and the arbiter resumes serving requests.
- Reset pulsed low mid-BUSY -> enableOut, completions and timeoutErr go to 0 immediately; state IDLE, and the first tie after reset is won by port 0.
